// File: rtl/register_file_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Reads and bypass are combinational; state and busy_cnt update on the next posedge.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] wa_0,
  input  logic [DATA_W-1:0] wd_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] wa_1,
  input  logic [DATA_W-1:0] wd_1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    if (BYPASS) begin
      if (we_1 && wa_1 == a)      v = wd_1;
      else if (we_0 && wa_0 == a) v = wd_0;
    end
    if (is_zero(a)) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy_q[a];
    if (BYPASS && ((we_1 && wa_1 == a) || (we_0 && wa_0 == a))) b = 1'b0;
    if (is_zero(a)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rd_data_1 = read_data(rd_addr_1);
    rd_data_2 = read_data(rd_addr_2);
    rd_busy_1 = read_busy(rd_addr_1);
    rd_busy_2 = read_busy(rd_addr_2);
  end

  // Clears (flush, write completion) are applied before the reserve so a new producer wins.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (we_1 && wa_1 == ADDR_W'(i)) begin
        regs_d[i] = wd_1;
        busy_d[i] = 1'b0;
      end else if (we_0 && wa_0 == ADDR_W'(i)) begin
        regs_d[i] = wd_0;
        busy_d[i] = 1'b0;
      end
      if (rsv_en && rsv_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
      if (is_zero(ADDR_W'(i))) begin
        regs_d[i] = '0;
        busy_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance share every input and are checked side by side.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_1, rd_addr_2, wa_0, wa_1, rsv_addr;
  logic        we_0, we_1, rsv_en, flush;
  logic [31:0] wd_0, wd_1;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_bz1, b_bz2, n_bz1, n_bz2;
  logic [5:0]  b_cnt, n_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(b_rd1), .rd_data_2(b_rd2), .rd_busy_1(b_bz1), .rd_busy_2(b_bz2),
    .we_0(we_0), .wa_0(wa_0), .wd_0(wd_0), .we_1(we_1), .wa_1(wa_1), .wd_1(wd_1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(b_cnt)
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(n_rd1), .rd_data_2(n_rd2), .rd_busy_1(n_bz1), .rd_busy_2(n_bz2),
    .we_0(we_0), .wa_0(wa_0), .wd_0(wd_0), .we_1(we_1), .wa_1(wa_1), .wd_1(wd_1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_0 = 1'b0; we_1 = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_1 = 5'd3; rd_addr_2 = 5'd7;
    wa_0 = 5'd3; wd_0 = 32'h1111_1111; wa_1 = 5'd7; wd_1 = 32'h2222_2222;
    rsv_addr = 5'd3; idle();
    we_0 = 1'b1; rsv_en = 1'b1;

    // 1: reset held over edges with activity on the inputs
    repeat (3) step();
    idle();
    #1;
    check("rst_rd1_b", b_rd1, 32'h0);
    check("rst_rd2_n", n_rd2, 32'h0);
    check("rst_bz1", {31'd0, b_bz1}, 32'h0);
    check("rst_cnt_b", {26'd0, b_cnt}, 32'h0);
    check("rst_cnt_n", {26'd0, n_cnt}, 32'h0);
    #2 rst_n = 1'b1;
    #1;
    check("rel_rd1", b_rd1, 32'h0);
    check("rel_cnt", {26'd0, b_cnt}, 32'h0);
    step();

    // 2: write with same-cycle read
    we_0 = 1'b1; wa_0 = 5'd3; wd_0 = 32'hDEAD_BEEF; rd_addr_1 = 5'd3;
    #1;
    check("wr_bypass", b_rd1, 32'hDEAD_BEEF);
    check("wr_nobyp_old", n_rd1, 32'h0);
    step();
    idle();
    #1;
    check("wr_nobyp_after", n_rd1, 32'hDEAD_BEEF);
    check("wr_byp_after", b_rd1, 32'hDEAD_BEEF);

    // 3: both ports to one address, port 1 wins
    we_0 = 1'b1; wa_0 = 5'd7; wd_0 = 32'd1;
    we_1 = 1'b1; wa_1 = 5'd7; wd_1 = 32'd2; rd_addr_2 = 5'd7;
    #1;
    check("dual_bypass", b_rd2, 32'd2);
    check("dual_nobyp_old", n_rd2, 32'd0);
    step();
    idle();
    #1;
    check("dual_stored_b", b_rd2, 32'd2);
    check("dual_stored_n", n_rd2, 32'd2);

    // 4: register 0 ignores writes and reserves
    we_0 = 1'b1; wa_0 = 5'd0; wd_0 = 32'd5; rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr_1 = 5'd0;
    #1;
    check("z_byp_rd", b_rd1, 32'd0);
    step();
    idle();
    #1;
    check("z_rd_b", b_rd1, 32'd0);
    check("z_rd_n", n_rd1, 32'd0);
    check("z_busy", {31'd0, n_bz1}, 32'd0);
    check("z_cnt", {26'd0, b_cnt}, 32'd0);

    // 5: scoreboard reserve / complete
    rsv_en = 1'b1; rsv_addr = 5'd4; step();
    rsv_addr = 5'd9; step();
    idle(); rd_addr_1 = 5'd4; rd_addr_2 = 5'd9;
    #1;
    check("sb_cnt2", {26'd0, b_cnt}, 32'd2);
    check("sb_busy4", {31'd0, b_bz1}, 32'd1);
    rsv_en = 1'b1; rsv_addr = 5'd4; we_1 = 1'b1; wa_1 = 5'd4; wd_1 = 32'h44;
    #1;
    check("sb_rw_byp_busy", {31'd0, b_bz1}, 32'd0);
    check("sb_rw_nb_busy", {31'd0, n_bz1}, 32'd1);
    step();
    idle();
    #1;
    check("sb_rw_busy_after", {31'd0, b_bz1}, 32'd1);
    check("sb_rw_data", n_rd1, 32'h44);
    check("sb_rw_cnt", {26'd0, n_cnt}, 32'd2);
    we_0 = 1'b1; wa_0 = 5'd9; wd_0 = 32'h99;
    #1;
    check("sb_wr9_byp_busy", {31'd0, b_bz2}, 32'd0);
    check("sb_wr9_nb_busy", {31'd0, n_bz2}, 32'd1);
    step();
    idle();
    #1;
    check("sb_cnt1", {26'd0, b_cnt}, 32'd1);
    check("sb_busy9_clr", {31'd0, n_bz2}, 32'd0);

    // 6: flush with same-cycle reserve and write
    rsv_en = 1'b1; rsv_addr = 5'd9; step();
    rsv_addr = 5'd12; step();
    idle();
    #1;
    check("fl_cnt3", {26'd0, b_cnt}, 32'd3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6;
    we_0 = 1'b1; wa_0 = 5'd5; wd_0 = 32'h55;
    #1;
    check("fl_not_bypassed", {31'd0, b_bz1}, 32'd1);
    step();
    idle(); rd_addr_1 = 5'd6; rd_addr_2 = 5'd4;
    #1;
    check("fl_cnt1", {26'd0, b_cnt}, 32'd1);
    check("fl_busy6", {31'd0, b_bz1}, 32'd1);
    check("fl_busy4", {31'd0, n_bz2}, 32'd0);
    rd_addr_2 = 5'd5;
    #1;
    check("fl_write_kept", n_rd2, 32'h55);

    // async reset mid-cycle
    rsv_en = 1'b1; rsv_addr = 5'd10; step();
    idle(); rd_addr_2 = 5'd3;
    #1;
    check("pre_rst_cnt", {26'd0, b_cnt}, 32'd2);
    check("pre_rst_data", b_rd2, 32'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", {26'd0, b_cnt}, 32'd0);
    check("mid_rst_busy", {31'd0, n_bz1}, 32'd0);
    check("mid_rst_data", n_rd2, 32'd0);
    check("mid_rst_data_b", b_rd2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
